// File: rtl/key_event.sv
// key_event: turns a debounced key level into press/release/long/repeat pulses and a held level.
module key_event #(
  parameter logic ACTIVE_LEVEL = 1'b0,
  parameter int   CLK_FREQ_Hz  = 27000000,
  parameter int   LONG_MS      = 1000,
  parameter int   REPEAT_MS    = 200,
  parameter logic REPEAT_EN    = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic key_db_i,
  output logic press_o,
  output logic release_o,
  output logic long_o,
  output logic repeat_o,
  output logic held_o
);
  localparam int DIV    = CLK_FREQ_Hz / 1000;
  localparam int MAX_MS = LONG_MS > REPEAT_MS ? LONG_MS : REPEAT_MS;
  localparam int MW     = $clog2(MAX_MS + 1);
  localparam int PW     = DIV > 1 ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PRE_TC  = PW'(DIV - 1);
  localparam logic [MW-1:0] LONG_TC = MW'(LONG_MS - 1);
  localparam logic [MW-1:0] REP_TC  = MW'(REPEAT_MS - 1);
  typedef enum logic [1:0] {S_IDLE, S_PRESSED, S_LONG} state_t;
  state_t r_state, w_next;
  logic r_sync1, r_sync2;
  logic [PW-1:0] r_presc;
  logic [MW-1:0] r_ms;
  logic r_press, r_release, r_long, r_repeat, r_held;
  logic w_pressed, w_tick, w_press, w_release, w_long, w_repeat, w_clr;
  assign w_pressed = r_sync2 == ACTIVE_LEVEL;
  assign w_tick    = r_presc == PRE_TC;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= ~ACTIVE_LEVEL;
      r_sync2 <= ~ACTIVE_LEVEL;
    end else begin
      r_sync1 <= key_db_i;
      r_sync2 <= r_sync1;
    end
  end
  // Thresholds fire on the tick that would carry the ms count up to the limit; release always wins.
  always_comb begin
    w_next    = r_state;
    w_press   = 1'b0;
    w_release = 1'b0;
    w_long    = 1'b0;
    w_repeat  = 1'b0;
    w_clr     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_pressed) begin
          w_next  = S_PRESSED;
          w_press = 1'b1;
          w_clr   = 1'b1;
        end
      end
      S_PRESSED: begin
        if (!w_pressed) begin
          w_next    = S_IDLE;
          w_release = 1'b1;
          w_clr     = 1'b1;
        end else if (w_tick && r_ms >= LONG_TC) begin
          w_next = S_LONG;
          w_long = 1'b1;
          w_clr  = 1'b1;
        end
      end
      S_LONG: begin
        if (!w_pressed) begin
          w_next    = S_IDLE;
          w_release = 1'b1;
          w_clr     = 1'b1;
        end else if (REPEAT_EN && w_tick && r_ms >= REP_TC) begin
          w_repeat = 1'b1;
          w_clr    = 1'b1;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_press   <= 1'b0;
      r_release <= 1'b0;
      r_long    <= 1'b0;
      r_repeat  <= 1'b0;
      r_held    <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_press   <= w_press;
      r_release <= w_release;
      r_long    <= w_long;
      r_repeat  <= w_repeat;
      r_held    <= w_next != S_IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (rst || w_clr) begin
      r_presc <= '0;
      r_ms    <= '0;
    end else begin
      r_presc <= w_tick ? '0 : r_presc + PW'(1);
      if (w_tick && r_ms != '1) r_ms <= r_ms + MW'(1);
    end
  end
  assign press_o   = r_press;
  assign release_o = r_release;
  assign long_o    = r_long;
  assign repeat_o  = r_repeat;
  assign held_o    = r_held;
endmodule
